// File: rtl/time_set_pkg.sv
// Shared definitions for the time-set controller: FSM state encoding,
// set_field codes and the default field limits.
package time_set_pkg;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_EDIT_HOUR = 3'd1,
        ST_EDIT_MIN  = 3'd2,
        ST_EDIT_SEC  = 3'd3,
        ST_COMMIT    = 3'd4
    } state_t;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    localparam int HOUR_MAX_DEF   = 23;
    localparam int MINSEC_MAX_DEF = 59;

    function automatic logic is_edit(input state_t s);
        return (s == ST_EDIT_HOUR) || (s == ST_EDIT_MIN) || (s == ST_EDIT_SEC);
    endfunction

endpackage

// File: rtl/time_set_ctrl_field_adjust.sv
// Combinational wrap-around increment/decrement of one time field.
// A value already above max_value snaps to 0 on any adjust.
module field_adjust (
    input  logic [5:0] value,
    input  logic [5:0] max_value,
    input  logic       up,
    input  logic       down,
    output logic [5:0] value_next
);

    // Up and down together cancel; otherwise wrap at the field limit.
    always_comb begin
        value_next = value;
        if (up && !down) begin
            if (value >= max_value) value_next = '0;
            else                    value_next = value + 6'd1;
        end else if (down && !up) begin
            if (value > max_value)  value_next = '0;
            else if (value == '0)   value_next = max_value;
            else                    value_next = value - 6'd1;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set controller: mode key walks hour -> min -> sec -> commit, up/down
// keys edit a shadow copy of the live time, commit strobes set_load.
// Optional edit timeout enabled by defining TIME_SET_TIMEOUT_EN.
//
// state     | meaning
// ----------+---------------------------------------------
// RUN       | idle, shadow time held, no field selected
// EDIT_HOUR | editing hour field
// EDIT_MIN  | editing minute field
// EDIT_SEC  | editing second field
// COMMIT    | one-cycle set_load strobe, then back to RUN
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int HOUR_MAX      = HOUR_MAX_DEF,
    parameter int MINSEC_MAX    = MINSEC_MAX_DEF,
    parameter int TIMEOUT_TICKS = 20
) (
    input  logic       set_clk,
    input  logic       set_rst,
    input  logic       set_mode_pulse,
    input  logic       set_up_pulse,
    input  logic       set_down_pulse,
    input  logic       set_blink_tick,
    input  logic [4:0] set_hour_in,
    input  logic [5:0] set_min_in,
    input  logic [5:0] set_sec_in,
    output logic [4:0] set_hour_out,
    output logic [5:0] set_min_out,
    output logic [5:0] set_sec_out,
    output logic       set_load,
    output logic [1:0] set_field,
    output logic       set_blink,
    output logic       set_active
);

    if (TIMEOUT_TICKS < 1 || HOUR_MAX > 31 || MINSEC_MAX > 63) begin : g_bad_params
        $error("time_set_ctrl: parameter out of range");
    end

    state_t     state, state_next;
    logic [4:0] hour_q;
    logic [5:0] min_q, sec_q;
    logic       blink_q, blink_next;
    logic [5:0] cur_value, cur_max, adj_value;
    logic       any_key, adjust_req, edit_now, timeout_hit;

    assign any_key    = set_mode_pulse | set_up_pulse | set_down_pulse;
    // Mode beats any adjust pulse; up with down cancels out.
    assign adjust_req = !set_mode_pulse && (set_up_pulse ^ set_down_pulse);
    assign edit_now   = is_edit(state);

`ifdef TIME_SET_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
    logic [TO_W-1:0] to_cnt;

    assign timeout_hit = edit_now && !any_key && set_blink_tick &&
                         (to_cnt == TO_W'(TIMEOUT_TICKS - 1));

    // Count idle blink ticks while editing; any key or state change restarts.
    always_ff @(posedge set_clk or posedge set_rst) begin
        if (set_rst)                                         to_cnt <= '0;
        else if (!edit_now || any_key || state_next != state) to_cnt <= '0;
        else if (set_blink_tick)                             to_cnt <= to_cnt + TO_W'(1);
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Select the field under edit and its limit for the shared adjuster.
    always_comb begin
        cur_value = '0;
        cur_max   = '0;
        case (state)
            ST_EDIT_HOUR: begin cur_value = {1'b0, hour_q}; cur_max = 6'(HOUR_MAX);   end
            ST_EDIT_MIN:  begin cur_value = min_q;          cur_max = 6'(MINSEC_MAX); end
            ST_EDIT_SEC:  begin cur_value = sec_q;          cur_max = 6'(MINSEC_MAX); end
            default:      ;
        endcase
    end

    field_adjust u_field_adjust (
        .value      (cur_value),
        .max_value  (cur_max),
        .up         (set_up_pulse),
        .down       (set_down_pulse),
        .value_next (adj_value)
    );

    // Next-state, blink and state-decoded outputs.
    always_comb begin
        state_next = state;
        set_load   = 1'b0;
        set_field  = FIELD_NONE;
        set_active = 1'b0;
        case (state)
            ST_RUN: if (set_mode_pulse) state_next = ST_EDIT_HOUR;
            ST_EDIT_HOUR: begin
                set_field  = FIELD_HOUR;
                set_active = 1'b1;
                if (set_mode_pulse)   state_next = ST_EDIT_MIN;
                else if (timeout_hit) state_next = ST_RUN;
            end
            ST_EDIT_MIN: begin
                set_field  = FIELD_MIN;
                set_active = 1'b1;
                if (set_mode_pulse)   state_next = ST_EDIT_SEC;
                else if (timeout_hit) state_next = ST_RUN;
            end
            ST_EDIT_SEC: begin
                set_field  = FIELD_SEC;
                set_active = 1'b1;
                if (set_mode_pulse)   state_next = ST_COMMIT;
                else if (timeout_hit) state_next = ST_RUN;
            end
            ST_COMMIT: begin
                set_load   = 1'b1;
                state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase

        if (!is_edit(state_next) || state_next != state || any_key) blink_next = 1'b0;
        else if (set_blink_tick)                                    blink_next = ~blink_q;
        else                                                        blink_next = blink_q;
    end

    // State, blink and shadow registers: capture on edit entry, adjust in edit.
    always_ff @(posedge set_clk or posedge set_rst) begin
        if (set_rst) begin
            state   <= ST_RUN;
            blink_q <= 1'b0;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
        end else begin
            state   <= state_next;
            blink_q <= blink_next;
            if (state == ST_RUN && set_mode_pulse) begin
                hour_q <= set_hour_in;
                min_q  <= set_min_in;
                sec_q  <= set_sec_in;
            end else if (edit_now && adjust_req) begin
                case (state)
                    ST_EDIT_HOUR: hour_q <= adj_value[4:0];
                    ST_EDIT_MIN:  min_q  <= adj_value;
                    ST_EDIT_SEC:  sec_q  <= adj_value;
                    default:      ;
                endcase
            end
        end
    end

    assign set_hour_out = hour_q;
    assign set_min_out  = min_q;
    assign set_sec_out  = sec_q;
    assign set_blink    = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed scenarios plus randomized
// key/tick traffic against a behavioural model. Timeout scenarios depend on
// TIME_SET_TIMEOUT_EN.
module tb_time_set_ctrl;

    localparam int HMAX = 23;
    localparam int MMAX = 59;
    localparam int TO   = 20;

    logic       set_clk = 1'b0;
    logic       set_rst = 1'b1;
    logic       set_mode_pulse = 1'b0, set_up_pulse = 1'b0, set_down_pulse = 1'b0;
    logic       set_blink_tick = 1'b0;
    logic [4:0] set_hour_in = '0;
    logic [5:0] set_min_in = '0, set_sec_in = '0;
    logic [4:0] set_hour_out;
    logic [5:0] set_min_out, set_sec_out;
    logic       set_load, set_blink, set_active;
    logic [1:0] set_field;

    int total = 0;
    int bad   = 0;
    int load_cnt = 0;

    // model: field 0=run, 1..3 = hour/min/sec edit, 4 = commit
    int m_field = 0, m_h = 0, m_m = 0, m_s = 0, m_to = 0;
    bit m_blink = 0;

    time_set_ctrl #(.HOUR_MAX(HMAX), .MINSEC_MAX(MMAX), .TIMEOUT_TICKS(TO)) dut (
        .set_clk        (set_clk),
        .set_rst        (set_rst),
        .set_mode_pulse (set_mode_pulse),
        .set_up_pulse   (set_up_pulse),
        .set_down_pulse (set_down_pulse),
        .set_blink_tick (set_blink_tick),
        .set_hour_in    (set_hour_in),
        .set_min_in     (set_min_in),
        .set_sec_in     (set_sec_in),
        .set_hour_out   (set_hour_out),
        .set_min_out    (set_min_out),
        .set_sec_out    (set_sec_out),
        .set_load       (set_load),
        .set_field      (set_field),
        .set_blink      (set_blink),
        .set_active     (set_active)
    );

    always #5 set_clk = ~set_clk;

    always @(negedge set_clk) if (set_load === 1'b1) load_cnt++;

    function automatic int adj(input int v, input int mx, input bit up);
        if (v > mx) return 0;
        if (up) return (v + 1) % (mx + 1);
        return (v + mx) % (mx + 1);
    endfunction

    task automatic model_reset();
        m_field = 0; m_h = 0; m_m = 0; m_s = 0; m_to = 0; m_blink = 0;
    endtask

    task automatic model_update(input bit m, input bit u, input bit d, input bit t);
        if (m_field == 0) begin
            if (m) begin
                m_h = set_hour_in; m_m = set_min_in; m_s = set_sec_in;
                m_field = 1;
            end
            m_blink = 0; m_to = 0;
        end else if (m_field == 4) begin
            m_field = 0; m_blink = 0; m_to = 0;
        end else if (m) begin
            m_field = m_field + 1; m_blink = 0; m_to = 0;
        end else if (u || d) begin
            if (u != d) begin
                if (m_field == 1)      m_h = adj(m_h, HMAX, u);
                else if (m_field == 2) m_m = adj(m_m, MMAX, u);
                else                   m_s = adj(m_s, MMAX, u);
            end
            m_blink = 0; m_to = 0;
        end else if (t) begin
            m_blink = !m_blink;
`ifdef TIME_SET_TIMEOUT_EN
            m_to = m_to + 1;
            if (m_to == TO) begin
                m_field = 0; m_blink = 0; m_to = 0;
            end
`endif
        end
    endtask

    task automatic step(input bit m, input bit u, input bit d, input bit t);
        set_mode_pulse = m; set_up_pulse = u; set_down_pulse = d; set_blink_tick = t;
        @(posedge set_clk);
        model_update(m, u, d, t);
        #1;
        set_mode_pulse = 0; set_up_pulse = 0; set_down_pulse = 0; set_blink_tick = 0;
    endtask

    task automatic set_live(input int h, input int mi, input int s);
        set_hour_in = 5'(h); set_min_in = 6'(mi); set_sec_in = 6'(s);
    endtask

    task automatic test_reset();
        set_rst = 1'b1;
        repeat (3) @(posedge set_clk);
        #1;
        total++; if (set_field !== 2'd0) begin bad++; $display("FAIL reset_field got=%0d exp=0", set_field); end
        total++; if (set_load !== 1'b0) begin bad++; $display("FAIL reset_load got=%0b exp=0", set_load); end
        total++; if (set_blink !== 1'b0) begin bad++; $display("FAIL reset_blink got=%0b exp=0", set_blink); end
        total++; if (set_active !== 1'b0) begin bad++; $display("FAIL reset_active got=%0b exp=0", set_active); end
        total++;
        if ({set_hour_out, set_min_out, set_sec_out} !== 17'd0) begin
            bad++; $display("FAIL reset_time got=%0d:%0d:%0d exp=0:0:0", set_hour_out, set_min_out, set_sec_out);
        end
        set_rst = 1'b0;
        model_reset();
    endtask

    task automatic test_example();
        int l0;
        l0 = load_cnt;
        set_live(12, 34, 56);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        set_live(1, 1, 1);
        step(1, 0, 0, 0);
        total++; if (set_load !== 1'b1) begin bad++; $display("FAIL example_load got=%0b exp=1", set_load); end
        total++;
        if (set_hour_out !== 5'd13 || set_min_out !== 6'd33 || set_sec_out !== 6'd56) begin
            bad++; $display("FAIL example_time got=%0d:%0d:%0d exp=13:33:56", set_hour_out, set_min_out, set_sec_out);
        end
        step(0, 0, 0, 0);
        total++; if (set_field !== 2'd0) begin bad++; $display("FAIL example_field_after got=%0d exp=0", set_field); end
        total++; if (set_load !== 1'b0) begin bad++; $display("FAIL example_load_after got=%0b exp=0", set_load); end
        total++; if (load_cnt - l0 != 1) begin bad++; $display("FAIL example_load_count got=%0d exp=1", load_cnt - l0); end
        total++;
        if (set_hour_out !== 5'd13 || set_min_out !== 6'd33) begin
            bad++; $display("FAIL example_hold_in_run got=%0d:%0d exp=13:33", set_hour_out, set_min_out);
        end
    endtask

    task automatic test_wrap();
        set_live(23, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        total++; if (set_hour_out !== 5'd0) begin bad++; $display("FAIL wrap_hour_up got=%0d exp=0", set_hour_out); end
        step(0, 0, 1, 0);
        total++; if (set_hour_out !== 5'd23) begin bad++; $display("FAIL wrap_hour_down got=%0d exp=23", set_hour_out); end
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        total++; if (set_min_out !== 6'd59) begin bad++; $display("FAIL wrap_min_down got=%0d exp=59", set_min_out); end
        step(0, 1, 0, 0);
        total++; if (set_min_out !== 6'd0) begin bad++; $display("FAIL wrap_min_up got=%0d exp=0", set_min_out); end
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask

    task automatic test_simultaneous();
        set_live(1, 2, 3);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        total++; if (set_field !== 2'd2) begin bad++; $display("FAIL modeup_field got=%0d exp=2", set_field); end
        total++; if (set_hour_out !== 5'd1) begin bad++; $display("FAIL modeup_hour got=%0d exp=1", set_hour_out); end
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        total++; if (set_sec_out !== 6'd3) begin bad++; $display("FAIL updown_sec got=%0d exp=3", set_sec_out); end
        total++; if (set_field !== 2'd3) begin bad++; $display("FAIL updown_field got=%0d exp=3", set_field); end
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_edit();
        int l0;
        l0 = load_cnt;
        set_live(5, 6, 7);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 1);
        set_rst = 1'b1;
        #2;
        total++; if (set_field !== 2'd0) begin bad++; $display("FAIL rstmid_field got=%0d exp=0", set_field); end
        total++; if (set_active !== 1'b0) begin bad++; $display("FAIL rstmid_active got=%0b exp=0", set_active); end
        total++;
        if ({set_hour_out, set_min_out, set_sec_out, set_blink, set_load} !== 19'd0) begin
            bad++; $display("FAIL rstmid_outputs got=%0d:%0d:%0d blink=%0b load=%0b exp=all 0",
                            set_hour_out, set_min_out, set_sec_out, set_blink, set_load);
        end
        set_rst = 1'b0;
        model_reset();
        repeat (5) step(0, 0, 0, 0);
        total++; if (load_cnt != l0) begin bad++; $display("FAIL rstmid_no_load got=%0d exp=0", load_cnt - l0); end
    endtask

    task automatic test_blink();
        bit exp_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        set_live(8, 9, 10);
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1);
            total++;
            if (set_blink !== exp_seq[i]) begin
                bad++; $display("FAIL blink_tick%0d got=%0b exp=%0b", i, set_blink, exp_seq[i]);
            end
        end
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        total++; if (set_blink !== 1'b0) begin bad++; $display("FAIL blink_clear_on_up got=%0b exp=0", set_blink); end
        total++; if (set_hour_out !== 5'd9) begin bad++; $display("FAIL blink_hour got=%0d exp=9", set_hour_out); end
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask

    task automatic test_timeout();
        int l0;
        l0 = load_cnt;
        set_live(10, 20, 30);
        step(1, 0, 0, 0);
`ifdef TIME_SET_TIMEOUT_EN
        repeat (TO - 1) step(0, 0, 0, 1);
        total++; if (set_field !== 2'd1) begin bad++; $display("FAIL timeout_before got=%0d exp=1", set_field); end
        step(0, 1, 0, 0);
        repeat (TO - 1) step(0, 0, 0, 1);
        total++; if (set_field !== 2'd1) begin bad++; $display("FAIL timeout_restart got=%0d exp=1", set_field); end
        step(0, 0, 0, 1);
        total++; if (set_field !== 2'd0) begin bad++; $display("FAIL timeout_exit got=%0d exp=0", set_field); end
        total++; if (set_hour_out !== 5'd11) begin bad++; $display("FAIL timeout_hour got=%0d exp=11", set_hour_out); end
        step(0, 0, 0, 0);
`else
        repeat (3 * TO) step(0, 0, 0, 1);
        total++; if (set_field !== 2'd1) begin bad++; $display("FAIL no_timeout_field got=%0d exp=1", set_field); end
        total++; if (set_active !== 1'b1) begin bad++; $display("FAIL no_timeout_active got=%0b exp=1", set_active); end
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        l0 = l0 + 1;
`endif
        total++; if (load_cnt != l0) begin bad++; $display("FAIL timeout_load_count got=%0d exp=%0d", load_cnt, l0); end
    endtask

    task automatic test_random();
        logic [1:0] ef;
        bit m, u, d, t;
        int kp;
        for (int i = 0; i < 2000; i++) begin
            kp = (i < 1000) ? 4 : 60;
            m = ($urandom_range(0, kp * 2) == 0);
            u = ($urandom_range(0, kp) == 0);
            d = ($urandom_range(0, kp) == 0);
            t = ($urandom_range(0, 2) == 0);
            set_hour_in = 5'($urandom);
            set_min_in  = 6'($urandom);
            set_sec_in  = 6'($urandom);
            step(m, u, d, t);
            ef = (m_field >= 1 && m_field <= 3) ? 2'(m_field) : 2'd0;
            total++;
            if (set_field !== ef) begin bad++; $display("FAIL rand_field cyc=%0d got=%0d exp=%0d", i, set_field, ef); end
            total++;
            if (set_load !== (m_field == 4)) begin bad++; $display("FAIL rand_load cyc=%0d got=%0b exp=%0b", i, set_load, m_field == 4); end
            total++;
            if (set_blink !== m_blink) begin bad++; $display("FAIL rand_blink cyc=%0d got=%0b exp=%0b", i, set_blink, m_blink); end
            total++;
            if (set_active !== (ef != 2'd0)) begin bad++; $display("FAIL rand_active cyc=%0d got=%0b exp=%0b", i, set_active, ef != 2'd0); end
            total++;
            if (set_hour_out !== 5'(m_h) || set_min_out !== 6'(m_m) || set_sec_out !== 6'(m_s)) begin
                bad++; $display("FAIL rand_time cyc=%0d got=%0d:%0d:%0d exp=%0d:%0d:%0d",
                                i, set_hour_out, set_min_out, set_sec_out, m_h, m_m, m_s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_example();
        test_wrap();
        test_simultaneous();
        test_reset_mid_edit();
        test_blink();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter HOUR_MAX, default 23: highest hour value; hour field wraps at this value.
REQ-002 Parameter MINSEC_MAX, default 59: highest minute and second value; both fields wrap at this value.
REQ-003 Parameter TIMEOUT_TICKS, default 20: number of set_blink_tick pulses without a key pulse before the edit is abandoned.
REQ-004 set_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 set_rst  input  1  reset, asynchronous and active-high.
REQ-006 set_mode_pulse  input  1  one-cycle pulse from the debouncer on a mode-key press.
REQ-007 set_up_pulse  input  1  one-cycle pulse from the debouncer on an up-key press.
REQ-008 set_down_pulse  input  1  one-cycle pulse from the debouncer on a down-key press.
REQ-009 set_blink_tick  input  1  one-cycle pulse at 2 Hz, from the divider.
REQ-010 set_hour_in / set_min_in / set_sec_in  input  5/6/6  live time from the time counter.
REQ-011 set_hour_out / set_min_out / set_sec_out  output  5/6/6  shadow (edited) time.
REQ-012 set_load  output  1  one-cycle strobe; the time counter loads the *_out values.
REQ-013 set_field  output  2  field being edited: 0=none, 1=hour, 2=min, 3=sec.
REQ-014 set_blink  output  1  high means blank the edited field on the display.
REQ-015 set_active  output  1  high in any edit state.

Function
REQ-016 The FSM SHALL have the states RUN, EDIT_HOUR, EDIT_MIN, EDIT_SEC and COMMIT.
REQ-017 In RUN, a set_mode_pulse SHALL capture set_*_in into the shadow registers and move the FSM to EDIT_HOUR on the same edge.
REQ-018 In any EDIT state, set_mode_pulse SHALL advance the FSM HOUR->MIN->SEC->COMMIT.
REQ-019 COMMIT SHALL last exactly one cycle with set_load=1, then return to RUN; set_load SHALL be 0 in every other state.
REQ-020 In EDIT states, set_up_pulse SHALL increment the current field and set_down_pulse SHALL decrement it, effective the next cycle.
REQ-021 Increment and decrement SHALL wrap: MAX+1 becomes 0 and 0-1 becomes MAX; hour uses HOUR_MAX, min and sec use MINSEC_MAX.
REQ-022 When up and down pulse in the same cycle, both SHALL be ignored.
REQ-023 When mode pulses together with up or down, mode SHALL win and the adjust pulse SHALL be dropped.
REQ-024 Up and down pulses in RUN or COMMIT SHALL be ignored.
REQ-025 set_blink SHALL toggle on each set_blink_tick while in an EDIT state.
REQ-026 set_blink SHALL clear to 0 on any field change or key pulse, and SHALL be held at 0 in RUN and COMMIT.
REQ-027 set_field SHALL follow the FSM state combinationally: 0 in RUN and COMMIT, 1/2/3 in EDIT_HOUR/EDIT_MIN/EDIT_SEC.
REQ-028 In RUN, set_*_out SHALL hold their last value and SHALL NOT track the inputs.
REQ-029 A shadow value above its MAX on entry to edit (corrupt input) SHALL be forced to 0 on the first adjust pulse.

Reset
REQ-030 set_rst SHALL immediately force state=RUN, all shadow registers to 0, set_load=0, set_blink=0 and the timeout counter to 0.
REQ-031 Reset asserted mid-edit SHALL discard the edit, with no set_load pulse.

Configuration
REQ-032 Macro TIME_SET_TIMEOUT_EN defined: a counter SHALL count set_blink_tick in EDIT states and clear on any key pulse or state change.
REQ-033 With TIME_SET_TIMEOUT_EN defined, reaching TIMEOUT_TICKS SHALL return the FSM to RUN with no set_load.
REQ-034 TIME_SET_TIMEOUT_EN undefined: no timeout counter SHALL exist and edit states SHALL persist indefinitely.

Structure
REQ-035 Package time_set_pkg SHALL hold the state encoding, the set_field codes and the default HOUR_MAX/MINSEC_MAX constants.
REQ-036 Sub-module field_adjust SHALL perform combinational wrap-around inc/dec (value, max, up, down -> next value) and SHALL be instantiated once and muxed by the current field.

Verification
REQ-037 Live 12:34:56, pulses mode, up, mode, down, mode, mode -> set_load once with hour=13, min=33, sec=56, then set_field=0.
REQ-038 In EDIT_HOUR with hour=23, pulse up -> hour=0; pulse down -> hour=23; in EDIT_MIN with min=0, pulse down -> min=59.
REQ-039 Up and down in the same cycle in EDIT_SEC -> sec unchanged; mode+up in the same cycle in EDIT_HOUR -> EDIT_MIN, hour unchanged.
REQ-040 set_rst pulsed while in EDIT_MIN -> state RUN, all outputs 0, and set_load never asserts.
REQ-041 TIME_SET_TIMEOUT_EN defined: enter edit, then 20 ticks with no key -> RUN, no set_load; a key pulse at tick 19 restarts the count.
REQ-042 In EDIT_HOUR, 4 ticks -> set_blink sequence 1,0,1,0; an up pulse forces set_blink=0 on the next cycle.
